// File: rtl/msk_rcon_sched.sv
// Masked AES-style round-constant sequencer: emits NR xtime-chained constants, share d-1 carries the value.
// Constant valid 1 cycle after start, one per cycle under rc_ready; rc_valid stalls hold rc_out/rc_idx.
module msk_rcon_sched #(
  parameter int             d       = 2,
  parameter int             W       = 8,
  parameter int             NR      = 12,
  parameter logic [W-1:0]   RC_INIT = W'(8'h01)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  output logic             busy,
  output logic             done,
  output logic             rc_valid,
  input  logic             rc_ready,
  output logic [W*d-1:0]   rc_out,
  output logic [3:0]       rc_idx
);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] RUN  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  localparam logic [3:0]   LAST = 4'(NR - 1);
  localparam logic [W-1:0] POLY = W'(8'h1B);

  logic [1:0]     state;
  logic [W-1:0]   rc_reg;
  logic [W-1:0]   rc_next;
  logic [3:0]     idx;
  logic [W*d-1:0] rc_enc;

  // GF(2^W) doubling of the current constant.
  always_comb begin
    rc_next = {rc_reg[W-2:0], 1'b0};
    if (rc_reg[W-1]) begin
      rc_next = rc_next ^ POLY;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      rc_reg <= RC_INIT;
      idx    <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state  <= RUN;
            rc_reg <= RC_INIT;
            idx    <= 4'd0;
          end
        end
        RUN: begin
          // abort wins over a same-cycle handshake
          if (abort) begin
            state  <= IDLE;
            rc_reg <= RC_INIT;
            idx    <= 4'd0;
          end else if (rc_ready) begin
            if (idx == LAST) begin
              state <= DONE;
              idx   <= 4'd0;
            end else begin
              rc_reg <= rc_next;
              idx    <= idx + 4'd1;
            end
          end
        end
        DONE: begin
          state  <= IDLE;
          rc_reg <= RC_INIT;
          idx    <= 4'd0;
        end
        default: begin
          state  <= IDLE;
          rc_reg <= RC_INIT;
          idx    <= 4'd0;
        end
      endcase
    end
  end

  // Trivial masking: top share holds the bit, lower shares are zero.
  for (genvar i = 0; i < W; i++) begin : g_enc
    assign rc_enc[i*d +: d] = {rc_reg[i], {(d-1){1'b0}}};
  end

  assign rc_valid = (state == RUN);
  assign busy     = (state == RUN) || (state == DONE);
  assign done     = (state == DONE);
  assign rc_out   = rc_valid ? rc_enc : '0;
  assign rc_idx   = rc_valid ? idx : 4'd0;

endmodule
